// File: rtl/depth_pkg.sv
// Shared types for the depth-test stage: compare functions, forwarding history entries
// and the compare helper used by the compare stage.
package depth_pkg;

    // History entries hold the widest supported address/depth; narrower instances zero-extend.
    localparam int HIST_ADDR_W  = 32;
    localparam int HIST_DEPTH_W = 32;

    typedef enum logic [1:0] {
        ALWAYS  = 2'b00,
        LESS    = 2'b01,
        LEQUAL  = 2'b10,
        GREATER = 2'b11
    } depth_func_t;

    typedef struct packed {
        logic                    valid;
        logic [HIST_ADDR_W-1:0]  addr;
        logic [HIST_DEPTH_W-1:0] depth;
    } hist_entry_t;

    function automatic logic depth_compare(
        input depth_func_t             func,
        input logic [HIST_DEPTH_W-1:0] new_d,
        input logic [HIST_DEPTH_W-1:0] old_d
    );
        logic pass;
        case (func)
            ALWAYS:  pass = 1'b1;
            LESS:    pass = (new_d < old_d);
            LEQUAL:  pass = (new_d <= old_d);
            default: pass = (new_d > old_d);
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/depth_fwd_window.sv
// Short history of recently committed depth writes; returns the youngest entry whose
// address matches the lookup so in-flight writes shadow stale BRAM data.
module depth_fwd_window
    import depth_pkg::*;
#(
    parameter int ADDR_W  = 17,
    parameter int DEPTH_W = 16,
    parameter int ENTRIES = 3
)(
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               push_valid,
    input  logic [ADDR_W-1:0]  push_addr,
    input  logic [DEPTH_W-1:0] push_depth,
    input  logic [ADDR_W-1:0]  lookup_addr,
    output logic               hit,
    output logic [DEPTH_W-1:0] depth
);

    hist_entry_t hist [ENTRIES];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < ENTRIES; i++) hist[i] <= '0;
        end else begin
            hist[0] <= '{valid: push_valid,
                         addr:  HIST_ADDR_W'(push_addr),
                         depth: HIST_DEPTH_W'(push_depth)};
            for (int i = 1; i < ENTRIES; i++) hist[i] <= hist[i-1];
        end
    end

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit   = 1'b0;
        depth = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (hist[i].valid && (hist[i].addr == HIST_ADDR_W'(lookup_addr))) begin
                hit   = 1'b1;
                depth = DEPTH_W'(hist[i].depth);
            end
        end
    end

endmodule

// File: rtl/depth_test_unit.sv
// Per-fragment depth test: issues the depth read, delays the fragment to meet the read data,
// compares against forwarded or BRAM depth, and emits gated framebuffer/depth writes.
module depth_test_unit
    import depth_pkg::*;
#(
    parameter int FB_BIT_WIDTH    = 16,
    parameter int DEPTH_BIT_WIDTH = 16,
    parameter int FB_ADDR_WIDTH   = 17,
    parameter int READ_LATENCY    = 2,
    parameter int VIS_BITS        = 8,
    parameter int STAT_WIDTH      = 32
)(
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       drawing_in,
    input  logic                       render_depth_buffer,
    input  logic [1:0]                 depth_func_in,
    input  logic                       fb_we_in,
    input  logic                       dp_we_in,
    input  logic                       fb_front_in,
    input  logic [FB_ADDR_WIDTH-1:0]   fb_write_in,
    input  logic [FB_BIT_WIDTH-1:0]    fb_value_in,
    input  logic [DEPTH_BIT_WIDTH-1:0] dp_value_in,
    input  logic [DEPTH_BIT_WIDTH-1:0] dp_read_in,
    input  logic                       clear_stats_in,
    output logic                       dp_re_out,
    output logic [FB_ADDR_WIDTH-1:0]   dp_read_addr_out,
    output logic                       fb_we_out,
    output logic                       dp_we_out,
    output logic                       fb_front_out,
    output logic [FB_ADDR_WIDTH-1:0]   fb_write_out,
    output logic [FB_ADDR_WIDTH-1:0]   dp_write_out,
    output logic [FB_BIT_WIDTH-1:0]    fb_value_out,
    output logic [DEPTH_BIT_WIDTH-1:0] dp_value_out,
    output logic [STAT_WIDTH-1:0]      pass_count_out,
    output logic [STAT_WIDTH-1:0]      reject_count_out
);

    localparam int STAGES = READ_LATENCY + 1;

    typedef struct packed {
        logic                       drawing;
        logic                       render;
        depth_func_t                func;
        logic                       fb_we;
        logic                       dp_we;
        logic                       front;
        logic [FB_ADDR_WIDTH-1:0]   addr;
        logic [FB_BIT_WIDTH-1:0]    colour;
        logic [DEPTH_BIT_WIDTH-1:0] depth;
    } frag_t;

    frag_t stage_q [STAGES];
    frag_t cur;

    logic                       fwd_hit;
    logic [DEPTH_BIT_WIDTH-1:0] fwd_depth;
    logic [DEPTH_BIT_WIDTH-1:0] old_depth;
    logic [VIS_BITS-1:0]        vis;
    logic                       pass;
    logic                       drawn;
    logic                       nxt_fb_we;
    logic                       nxt_dp_we;
    logic [FB_BIT_WIDTH-1:0]    nxt_value;

    // Read issue and the fragment delay line share the input sample edge, so the last
    // stage lines up with the BRAM data READ_LATENCY cycles after the address.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dp_re_out        <= 1'b0;
            dp_read_addr_out <= '0;
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            dp_re_out        <= drawing_in & (fb_we_in | dp_we_in);
            dp_read_addr_out <= fb_write_in;
            stage_q[0] <= '{drawing: drawing_in,
                            render:  render_depth_buffer,
                            func:    depth_func_t'(depth_func_in),
                            fb_we:   fb_we_in,
                            dp_we:   dp_we_in,
                            front:   fb_front_in,
                            addr:    fb_write_in,
                            colour:  fb_value_in,
                            depth:   dp_value_in};
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign cur = stage_q[STAGES-1];

    // One entry per output cycle, so a write is visible to fragments up to
    // READ_LATENCY+1 cycles younger, after which the BRAM read already sees it.
    depth_fwd_window #(
        .ADDR_W  (FB_ADDR_WIDTH),
        .DEPTH_W (DEPTH_BIT_WIDTH),
        .ENTRIES (STAGES)
    ) u_fwd (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .push_valid  (nxt_dp_we),
        .push_addr   (cur.addr),
        .push_depth  (cur.depth),
        .lookup_addr (cur.addr),
        .hit         (fwd_hit),
        .depth       (fwd_depth)
    );

    always_comb begin
        old_depth = fwd_hit ? fwd_depth : dp_read_in;
        pass      = depth_compare(cur.func, HIST_DEPTH_W'(cur.depth), HIST_DEPTH_W'(old_depth));
        drawn     = cur.drawing & (cur.fb_we | cur.dp_we);
        vis       = ~cur.depth[DEPTH_BIT_WIDTH-1 -: VIS_BITS];
        nxt_fb_we = cur.fb_we;
        nxt_dp_we = cur.dp_we;
        nxt_value = cur.colour;
        if (cur.drawing) begin
            nxt_fb_we = cur.fb_we & pass;
            nxt_dp_we = cur.dp_we & pass;
            if (cur.render) nxt_value = FB_BIT_WIDTH'(vis);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fb_we_out    <= 1'b0;
            dp_we_out    <= 1'b0;
            fb_front_out <= 1'b0;
            fb_write_out <= '0;
            dp_write_out <= '0;
            fb_value_out <= '0;
            dp_value_out <= '0;
        end else begin
            fb_we_out    <= nxt_fb_we;
            dp_we_out    <= nxt_dp_we;
            fb_front_out <= cur.front;
            fb_write_out <= cur.addr;
            dp_write_out <= cur.addr;
            fb_value_out <= nxt_value;
            dp_value_out <= cur.depth;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pass_count_out   <= '0;
            reject_count_out <= '0;
        end else if (clear_stats_in) begin
            pass_count_out   <= '0;
            reject_count_out <= '0;
        end else if (drawn) begin
            if (pass) begin
                if (pass_count_out != '1) pass_count_out <= pass_count_out + STAT_WIDTH'(1);
            end else begin
                if (reject_count_out != '1) reject_count_out <= reject_count_out + STAT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_depth_test_unit.sv
// Directed bench for depth_test_unit with a latency-matched depth BRAM model and a write log.
module tb_depth_test_unit;
    import depth_pkg::*;

    localparam int L  = 2;
    localparam int SW = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        drawing_in, render_depth_buffer, fb_we_in, dp_we_in, fb_front_in, clear_stats_in;
    logic [1:0]  depth_func_in;
    logic [16:0] fb_write_in;
    logic [15:0] fb_value_in, dp_value_in, dp_read_in;
    logic        dp_re_out, fb_we_out, dp_we_out, fb_front_out;
    logic [16:0] dp_read_addr_out, fb_write_out, dp_write_out;
    logic [15:0] fb_value_out, dp_value_out;
    logic [SW-1:0] pass_count_out, reject_count_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    depth_test_unit #(
        .FB_BIT_WIDTH(16), .DEPTH_BIT_WIDTH(16), .FB_ADDR_WIDTH(17),
        .READ_LATENCY(L), .VIS_BITS(8), .STAT_WIDTH(SW)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .drawing_in(drawing_in),
        .render_depth_buffer(render_depth_buffer), .depth_func_in(depth_func_in),
        .fb_we_in(fb_we_in), .dp_we_in(dp_we_in), .fb_front_in(fb_front_in),
        .fb_write_in(fb_write_in), .fb_value_in(fb_value_in), .dp_value_in(dp_value_in),
        .dp_read_in(dp_read_in), .clear_stats_in(clear_stats_in),
        .dp_re_out(dp_re_out), .dp_read_addr_out(dp_read_addr_out),
        .fb_we_out(fb_we_out), .dp_we_out(dp_we_out), .fb_front_out(fb_front_out),
        .fb_write_out(fb_write_out), .dp_write_out(dp_write_out),
        .fb_value_out(fb_value_out), .dp_value_out(dp_value_out),
        .pass_count_out(pass_count_out), .reject_count_out(reject_count_out)
    );

    // Depth BRAM: two read registers give latency L=2; writes commit at the edge.
    logic [15:0] mem [0:31];
    logic [15:0] rd1, rd2;
    logic        pre_we;
    logic [4:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk_in) begin
        rd1 <= mem[dp_read_addr_out[4:0]];
        rd2 <= rd1;
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (dp_we_out) mem[dp_write_out[4:0]] <= dp_value_out;
    end
    assign dp_read_in = rd2;

    typedef struct {
        logic [16:0] addr;
        logic [15:0] fbv;
        logic [15:0] dpv;
    } wr_t;
    wr_t log_q [$];

    always @(negedge clk_in) begin
        if (fb_we_out || dp_we_out) log_q.push_back('{fb_write_out, fb_value_out, dp_value_out});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk_in); #1;
        pre_we = 1'b0;
    endtask

    task automatic frag(input logic draw, input logic rdb, input depth_func_t f,
                        input logic [16:0] a, input logic [15:0] col, input logic [15:0] dep);
        drawing_in = draw; render_depth_buffer = rdb; depth_func_in = f;
        fb_we_in = 1'b1; dp_we_in = 1'b1; fb_front_in = 1'b1;
        fb_write_in = a; fb_value_in = col; dp_value_in = dep;
        @(posedge clk_in); #1;
        drawing_in = 1'b0; render_depth_buffer = 1'b0; fb_we_in = 1'b0; dp_we_in = 1'b0;
    endtask

    task automatic chk_log(input string tag, input int n, input logic [15:0] last_dp);
        chk({tag, "_writes"}, 32'(log_q.size()), 32'(n));
        if (log_q.size() > 0) chk({tag, "_last_depth"}, 32'(log_q[$].dpv), 32'(last_dp));
    endtask

    initial begin
        rst_n_in = 1'b0; drawing_in = 1'b0; render_depth_buffer = 1'b0; fb_we_in = 1'b0;
        dp_we_in = 1'b0; fb_front_in = 1'b0; clear_stats_in = 1'b0; depth_func_in = 2'b00;
        fb_write_in = '0; fb_value_in = '0; dp_value_in = '0; pre_we = 1'b0;
        pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 32; i++) preload(5'(i), 16'hFFFF);

        chk("rst_fb_we", 32'(fb_we_out), 32'd0);
        chk("rst_dp_we", 32'(dp_we_out), 32'd0);
        chk("rst_re", 32'(dp_re_out), 32'd0);
        chk("rst_value", 32'(fb_value_out), 32'd0);
        chk("rst_pass", 32'(pass_count_out), 32'd0);
        chk("rst_reject", 32'(reject_count_out), 32'd0);

        @(negedge clk_in) rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        preload(5'd5, 16'h4000);

        // LEQUAL equal depth passes, with exact read and write latency
        log_q.delete();
        frag(1'b1, 1'b0, LEQUAL, 17'd5, 16'hABCD, 16'h4000);
        chk("re_issue", 32'(dp_re_out), 32'd1);
        chk("re_addr", 32'(dp_read_addr_out), 32'd5);
        idle(L + 1);
        chk("leq_fb_we", 32'(fb_we_out), 32'd1);
        chk("leq_dp_we", 32'(dp_we_out), 32'd1);
        chk("leq_addr", 32'(fb_write_out), 32'd5);
        chk("leq_value", 32'(fb_value_out), 32'hABCD);
        chk("leq_depth", 32'(dp_value_out), 32'h4000);
        chk("leq_front", 32'(fb_front_out), 32'd1);
        chk("leq_pass", 32'(pass_count_out), 32'd1);
        idle(4);

        // LESS with equal depth rejects; address still tracks the fragment
        frag(1'b1, 1'b0, LESS, 17'd5, 16'hABCD, 16'h4000);
        idle(L + 1);
        chk("less_fb_we", 32'(fb_we_out), 32'd0);
        chk("less_dp_we", 32'(dp_we_out), 32'd0);
        chk("less_addr", 32'(fb_write_out), 32'd5);
        chk("less_reject", 32'(reject_count_out), 32'd1);
        idle(4);

        // Back-to-back to addr 9: second must see the forwarded 0x3000, not stale 0xFFFF
        log_q.delete();
        frag(1'b1, 1'b0, LEQUAL, 17'd9, 16'h1111, 16'h3000);
        frag(1'b1, 1'b0, LEQUAL, 17'd9, 16'h2222, 16'h5000);
        idle(6);
        chk_log("b2b", 1, 16'h3000);

        // Gap L+2: the BRAM already holds the first write
        log_q.delete();
        frag(1'b1, 1'b0, LEQUAL, 17'd10, 16'h1111, 16'h3000);
        idle(L + 1);
        frag(1'b1, 1'b0, LEQUAL, 17'd10, 16'h2222, 16'h5000);
        idle(6);
        chk_log("gap_bram", 1, 16'h3000);

        // Gap L+1: oldest forwarding slot
        log_q.delete();
        frag(1'b1, 1'b0, LEQUAL, 17'd11, 16'h1111, 16'h3000);
        idle(L);
        frag(1'b1, 1'b0, LEQUAL, 17'd11, 16'h2222, 16'h5000);
        idle(6);
        chk_log("gap_edge", 1, 16'h3000);

        // Closer fragment follows through forwarding
        log_q.delete();
        frag(1'b1, 1'b0, LEQUAL, 17'd12, 16'h1111, 16'h3000);
        frag(1'b1, 1'b0, LEQUAL, 17'd12, 16'h2222, 16'h2000);
        idle(6);
        chk_log("b2b_pass", 2, 16'h2000);

        // GREATER against far plane rejects, ALWAYS passes
        log_q.delete();
        frag(1'b1, 1'b0, GREATER, 17'd13, 16'h1111, 16'h1000);
        idle(6);
        frag(1'b1, 1'b0, ALWAYS, 17'd13, 16'h2222, 16'h1000);
        idle(6);
        chk_log("gt_always", 1, 16'h1000);

        // Youngest match wins: 0x2800 vs 0x2000 (youngest) rejects, vs 0x3000 would pass
        log_q.delete();
        frag(1'b1, 1'b0, LEQUAL, 17'd14, 16'h1111, 16'h3000);
        frag(1'b1, 1'b0, LEQUAL, 17'd14, 16'h2222, 16'h2000);
        frag(1'b1, 1'b0, LEQUAL, 17'd14, 16'h3333, 16'h2800);
        idle(6);
        chk_log("youngest", 2, 16'h2000);
        chk("mid_pass", 32'(pass_count_out), 32'd9);
        chk("mid_reject", 32'(reject_count_out), 32'd6);

        // Clear sweep over stale 0x1000 entries, then a drawn fragment using the forwarded clear
        for (int i = 20; i < 24; i++) preload(5'(i), 16'h1000);
        log_q.delete();
        for (int i = 20; i < 24; i++) frag(1'b0, 1'b0, LEQUAL, 17'(i), 16'hFFFF, 16'hFFFF);
        frag(1'b1, 1'b0, LEQUAL, 17'd23, 16'h7777, 16'h8000);
        idle(6);
        chk_log("clear", 5, 16'h8000);
        if (log_q.size() > 0) begin
            chk("clear_addr0", 32'(log_q[0].addr), 32'd20);
            chk("clear_fbv0", 32'(log_q[0].fbv), 32'hFFFF);
            chk("clear_dpv0", 32'(log_q[0].dpv), 32'hFFFF);
        end
        chk("clear_pass", 32'(pass_count_out), 32'd10);
        chk("clear_reject", 32'(reject_count_out), 32'd6);

        // Depth visualisation: ~0x12 = 0xED
        log_q.delete();
        frag(1'b1, 1'b1, ALWAYS, 17'd24, 16'h5555, 16'h12AB);
        idle(6);
        chk("vis_writes", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) chk("vis_value", 32'(log_q[0].fbv), 32'h00ED);

        // Reset with three fragments in flight
        frag(1'b1, 1'b0, ALWAYS, 17'd25, 16'h1111, 16'h0100);
        frag(1'b1, 1'b0, ALWAYS, 17'd26, 16'h2222, 16'h0200);
        frag(1'b1, 1'b0, ALWAYS, 17'd27, 16'h3333, 16'h0300);
        rst_n_in = 1'b0;
        #1;
        chk("mrst_fb_we", 32'(fb_we_out), 32'd0);
        chk("mrst_re", 32'(dp_re_out), 32'd0);
        chk("mrst_raddr", 32'(dp_read_addr_out), 32'd0);
        chk("mrst_pass", 32'(pass_count_out), 32'd0);
        chk("mrst_dpv", 32'(dp_value_out), 32'd0);
        log_q.delete();
        idle(2);
        @(negedge clk_in) rst_n_in = 1'b1;
        idle(6);
        chk("mrst_no_writes", 32'(log_q.size()), 32'd0);

        // Saturation at 2^SW-1, then a reject, then clear overriding increments
        for (int i = 0; i < 17; i++) frag(1'b1, 1'b0, ALWAYS, 17'd0, 16'h0001, 16'h0001);
        idle(6);
        chk("sat_pass", 32'(pass_count_out), 32'd15);
        frag(1'b1, 1'b0, GREATER, 17'd1, 16'h0001, 16'h0000);
        idle(6);
        chk("sat_reject", 32'(reject_count_out), 32'd1);
        chk("sat_hold", 32'(pass_count_out), 32'd15);
        clear_stats_in = 1'b1;
        frag(1'b1, 1'b0, ALWAYS, 17'd2, 16'h0001, 16'h0001);
        idle(6);
        clear_stats_in = 1'b0;
        chk("clr_pass", 32'(pass_count_out), 32'd0);
        chk("clr_reject", 32'(reject_count_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
